alu_serial_ctrl: RTL

- Bit-serial sequencer that drives a combinational 1-bit ALU slice and collects its output.
- Accepts WIDTH-bit operands plus an opcode through a start/busy/done handshake.
- Presents one operand bit pair per cycle, LSB first, on the ALU-facing ports, and captures the slice output each cycle.
- Assembles the WIDTH-bit result and holds it until the next operation.

---
 rtl/alu_serial_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a combinational 1-bit ALU slice: streams latched
// operands LSB first and assembles the slice output into a WIDTH-bit result.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Select,
  input  logic             Mode,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [1:0]       AluSelect,
  output logic             AluMode,
  output logic             AluA,
  output logic             AluB,
  input  logic             AluOutput
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_sr, opb_sr;
  logic [1:0]       sel_q;
  logic             mode_q;
  logic             accept, last;

  // DONE doubles as an accept slot so back-to-back ops lose no cycle
  assign accept = Start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = Start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      opa_sr <= '0;
      opb_sr <= '0;
      sel_q  <= 2'b00;
      mode_q <= 1'b0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      opa_sr <= OpA;
      opb_sr <= OpB;
      sel_q  <= Select;
      mode_q <= Mode;
      cnt    <= '0;
    end else if (state == RUN) begin
      // slice output enters at the MSB; after WIDTH shifts bit i lines up with operand bit i
      Result <= {AluOutput, Result[WIDTH-1:1]};
      opa_sr <= opa_sr >> 1;
      opb_sr <= opb_sr >> 1;
      cnt    <= last ? '0 : cnt + CW'(1);
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign AluSelect = sel_q;
  assign AluMode   = mode_q;
  assign AluA      = Busy & opa_sr[0];
  assign AluB      = Busy & opb_sr[0];

endmodule
